// File: rtl/decode_issue_controller.sv
// Issue/hazard controller between decode and execute: load scoreboard, outstanding-load
// limit, post-redirect drop window and stall-cycle monitor.
module decode_issue_controller #(
  parameter int LOAD_LIMIT      = 4,
  parameter int FLUSH_CYCLES    = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       INS_VALID,
  output logic                       INS_READY,
  input  logic [4:0]                 RS1_ADDRESS,
  input  logic                       RS1_USED,
  input  logic [4:0]                 RS2_ADDRESS,
  input  logic                       RS2_USED,
  input  logic [4:0]                 RD_ADDRESS,
  input  logic                       RD_WRITE_ENABLE,
  input  logic                       IS_LOAD,
  input  logic                       EX_READY,
  output logic                       ISSUE_VALID,
  output logic                       BUBBLE,
  input  logic                       WB_VALID,
  input  logic [4:0]                 WB_RD_ADDRESS,
  input  logic                       FLUSH,
  output logic                       STALL,
  output logic [1:0]                 STATE,
  output logic [3:0]                 LOAD_COUNT,
  output logic [STALL_CNT_WIDTH-1:0] STALL_CYCLES
);

  // state        | meaning
  // RUN          | issuing normally
  // HAZARD_STALL | valid instruction held on a hazard
  // FLUSH_DRAIN  | wrong-path instructions consumed and dropped
  typedef enum logic [1:0] {
    RUN          = 2'b00,
    HAZARD_STALL = 2'b01,
    FLUSH_DRAIN  = 2'b10
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] LOAD_MAX   = 4'(LOAD_LIMIT);

  state_t      state, state_nxt;
  logic [3:0]  drain_cnt, drain_nxt;
  logic [31:0] pending, pending_nxt, pend_eff, wb_mask;
  logic        hazard, drop, issue, load_issue, wb_dec;

  // A write-back completing this cycle already satisfies its readers.
  assign wb_mask  = WB_VALID ? (32'd1 << WB_RD_ADDRESS) : 32'd0;
  assign pend_eff = pending & ~wb_mask;

  assign hazard = (RS1_USED & pend_eff[RS1_ADDRESS])
                | (RS2_USED & pend_eff[RS2_ADDRESS])
                | (RD_WRITE_ENABLE & pend_eff[RD_ADDRESS])
                | (IS_LOAD & (LOAD_COUNT == LOAD_MAX) & ~WB_VALID);

  assign drop  = FLUSH | (state == FLUSH_DRAIN);
  assign issue = INS_VALID & ~hazard & EX_READY & ~drop & ~RST;

  assign ISSUE_VALID = issue;
  assign INS_READY   = issue | (INS_VALID & drop & ~RST);
  assign BUBBLE      = ~issue;
  assign STALL       = INS_VALID & ~drop & ~issue & ~RST;
  assign STATE       = state;

  assign load_issue = issue & IS_LOAD;
  assign wb_dec     = WB_VALID & (LOAD_COUNT != 4'd0);

  always_comb begin
    pending_nxt = pending & ~wb_mask;
    if (load_issue && RD_WRITE_ENABLE && (RD_ADDRESS != 5'd0))
      pending_nxt[RD_ADDRESS] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    if (FLUSH) begin
      drain_nxt = DRAIN_LOAD;
      state_nxt = (DRAIN_LOAD == 4'd0) ? RUN : FLUSH_DRAIN;
    end else begin
      case (state)
        RUN:          if (INS_VALID && hazard) state_nxt = HAZARD_STALL;
        HAZARD_STALL: if (!(INS_VALID && hazard)) state_nxt = RUN;
        FLUSH_DRAIN: begin
          if (drain_cnt <= 4'd1) begin
            drain_nxt = 4'd0;
            state_nxt = RUN;
          end else begin
            drain_nxt = drain_cnt - 4'd1;
          end
        end
        default:      state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= RUN;
      drain_cnt    <= 4'd0;
      pending      <= 32'd0;
      LOAD_COUNT   <= 4'd0;
      STALL_CYCLES <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      pending   <= pending_nxt;
      case ({load_issue, wb_dec})
        2'b10:   LOAD_COUNT <= LOAD_COUNT + 4'd1;
        2'b01:   LOAD_COUNT <= LOAD_COUNT - 4'd1;
        default: LOAD_COUNT <= LOAD_COUNT;
      endcase
      if (STALL && (STALL_CYCLES != {STALL_CNT_WIDTH{1'b1}}))
        STALL_CYCLES <= STALL_CYCLES + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue_controller.sv
// Self-checking bench: per-cycle vector table through an expectation queue, plus a
// reset-during-drain sequence.
module tb_decode_issue_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INS_VALID, INS_READY;
  logic [4:0]  RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS, WB_RD_ADDRESS;
  logic        RS1_USED, RS2_USED, RD_WRITE_ENABLE, IS_LOAD, EX_READY;
  logic        ISSUE_VALID, BUBBLE, WB_VALID, FLUSH, STALL;
  logic [1:0]  STATE;
  logic [3:0]  LOAD_COUNT;
  logic [15:0] STALL_CYCLES;

  decode_issue_controller #(.LOAD_LIMIT(4), .FLUSH_CYCLES(2), .STALL_CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .INS_VALID(INS_VALID), .INS_READY(INS_READY),
    .RS1_ADDRESS(RS1_ADDRESS), .RS1_USED(RS1_USED), .RS2_ADDRESS(RS2_ADDRESS),
    .RS2_USED(RS2_USED), .RD_ADDRESS(RD_ADDRESS), .RD_WRITE_ENABLE(RD_WRITE_ENABLE),
    .IS_LOAD(IS_LOAD), .EX_READY(EX_READY), .ISSUE_VALID(ISSUE_VALID), .BUBBLE(BUBBLE),
    .WB_VALID(WB_VALID), .WB_RD_ADDRESS(WB_RD_ADDRESS), .FLUSH(FLUSH), .STALL(STALL),
    .STATE(STATE), .LOAD_COUNT(LOAD_COUNT), .STALL_CYCLES(STALL_CYCLES)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] rd;
    logic       we, ld, exr, wbv;
    logic [4:0] wbrd;
    logic       fl;
    logic       iv, ir, st;
    logic [1:0] sta;
    logic [3:0] lc;
    int         sc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   sc_model = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                     input logic we, input logic ld, input logic exr, input logic wbv,
                     input logic [4:0] wbrd, input logic fl, input logic iv,
                     input logic ir, input logic st, input logic [1:0] sta,
                     input logic [3:0] lc);
    vec_t x;
    x.v = v; x.r1 = r1; x.u1 = u1; x.r2 = r2; x.u2 = u2; x.rd = rd; x.we = we;
    x.ld = ld; x.exr = exr; x.wbv = wbv; x.wbrd = wbrd; x.fl = fl;
    x.iv = iv; x.ir = ir; x.st = st; x.sta = sta; x.lc = lc;
    x.sc = sc_model;
    sc_model += int'(st);
    vecs.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    INS_VALID = x.v; RS1_ADDRESS = x.r1; RS1_USED = x.u1; RS2_ADDRESS = x.r2;
    RS2_USED = x.u2; RD_ADDRESS = x.rd; RD_WRITE_ENABLE = x.we; IS_LOAD = x.ld;
    EX_READY = x.exr; WB_VALID = x.wbv; WB_RD_ADDRESS = x.wbrd; FLUSH = x.fl;
  endtask

  task automatic drive_instr(input logic ld, input logic [4:0] r1, input logic u1,
                             input logic [4:0] rd, input logic fl);
    vec_t x;
    x = '{v:1, r1:r1, u1:u1, r2:0, u2:0, rd:rd, we:1, ld:ld, exr:1, wbv:0, wbrd:0,
          fl:fl, iv:0, ir:0, st:0, sta:0, lc:0, sc:0};
    drive(x);
  endtask

  initial begin
    vec_t cur, e;
    RST = 1'b1;
    drive_instr(1'b0, 5'd0, 1'b0, 5'd3, 1'b0);
    #2;
    chk("rst_issue_valid", int'(ISSUE_VALID), 0);
    chk("rst_ins_ready", int'(INS_READY), 0);
    chk("rst_stall", int'(STALL), 0);
    chk("rst_bubble", int'(BUBBLE), 1);
    chk("rst_state", int'(STATE), 0);
    chk("rst_load_count", int'(LOAD_COUNT), 0);
    chk("rst_stall_cycles", int'(STALL_CYCLES), 0);

    // v r1 u1 r2 u2 rd we ld exr wbv wbrd fl | iv ir st state lc
    // RAW on load x5, write-back three cycles after the ADD
    add(1,1,1,0,0,5,1,1,1,0,0,0, 1,1,0,0,0);
    add(1,5,1,1,1,6,1,0,1,0,0,0, 0,0,1,0,1);
    add(1,5,1,1,1,6,1,0,1,0,0,0, 0,0,1,1,1);
    add(1,5,1,1,1,6,1,0,1,0,0,0, 0,0,1,1,1);
    add(1,5,1,1,1,6,1,0,1,1,5,0, 1,1,0,1,1);
    add(1,5,1,0,0,7,1,0,1,0,0,0, 1,1,0,0,0);
    // load limit
    add(1,0,0,0,0,1,1,1,1,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,2,1,1,1,0,0,0, 1,1,0,0,1);
    add(1,0,0,0,0,3,1,1,1,0,0,0, 1,1,0,0,2);
    add(1,0,0,0,0,4,1,1,1,0,0,0, 1,1,0,0,3);
    add(1,0,0,0,0,7,1,1,1,0,0,0, 0,0,1,0,4);
    add(1,0,0,0,0,7,1,1,1,1,1,0, 1,1,0,1,4);
    add(0,0,0,0,0,0,0,0,1,1,2,0, 0,0,0,0,4);
    add(0,0,0,0,0,0,0,0,1,1,3,0, 0,0,0,0,3);
    add(0,0,0,0,0,0,0,0,1,1,4,0, 0,0,0,0,2);
    add(0,0,0,0,0,0,0,0,1,1,7,0, 0,0,0,0,1);
    // load to x0 never makes x0 pending
    add(1,0,0,0,0,0,1,1,1,0,0,0, 1,1,0,0,0);
    add(1,0,1,0,1,0,1,0,1,0,0,0, 1,1,0,0,1);
    add(0,0,0,0,0,0,0,0,1,1,0,0, 0,0,0,0,1);
    // flush while stalled on hazard
    add(1,0,0,0,0,8,1,1,1,0,0,0, 1,1,0,0,0);
    add(1,8,1,0,0,10,1,0,1,0,0,0, 0,0,1,0,1);
    add(1,8,1,0,0,10,1,0,1,0,0,0, 0,0,1,1,1);
    add(1,8,1,0,0,10,1,0,1,0,0,1, 0,1,0,1,1);
    add(1,8,1,0,0,10,1,0,1,0,0,0, 0,1,0,2,1);
    add(1,1,1,0,0,10,1,0,1,0,0,0, 1,1,0,0,1);
    add(0,0,0,0,0,0,0,0,1,1,8,0, 0,0,0,0,1);
    // EX_READY low stalls without leaving RUN
    add(1,1,1,2,1,3,1,0,0,0,0,0, 0,0,1,0,0);
    add(1,1,1,2,1,3,1,0,1,0,0,0, 1,1,0,0,0);
    // same-cycle issue and write-back of x9: set wins, count unchanged
    add(1,0,0,0,0,11,1,1,1,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,9,1,1,1,1,9,0, 1,1,0,0,1);
    add(1,9,1,0,0,13,1,0,1,0,0,0, 0,0,1,0,1);
    add(0,0,0,0,0,0,0,0,1,1,9,0, 0,0,0,1,1);
    add(1,9,1,0,0,13,1,0,1,0,0,0, 1,1,0,0,0);
    add(0,0,0,0,0,0,0,0,1,1,11,0, 0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0);
    // WAW
    add(1,0,0,0,0,12,1,1,1,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,12,1,0,1,0,0,0, 0,0,1,0,1);
    add(1,0,0,0,0,12,1,0,1,1,12,0, 1,1,0,1,1);
    add(0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0);
    // flush reload during drain
    add(1,0,0,0,0,14,1,0,1,0,0,1, 0,1,0,0,0);
    add(1,0,0,0,0,14,1,0,1,0,0,1, 0,1,0,2,0);
    add(1,0,0,0,0,14,1,0,1,0,0,0, 0,1,0,2,0);
    add(1,0,0,0,0,14,1,0,1,0,0,0, 1,1,0,0,0);

    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge CLK);
      cur = vecs[i];
      drive(cur);
      exp_q.push_back(cur);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_issue_valid", i), int'(ISSUE_VALID), int'(e.iv));
      chk($sformatf("v%0d_ins_ready", i), int'(INS_READY), int'(e.ir));
      chk($sformatf("v%0d_bubble", i), int'(BUBBLE), int'(!e.iv));
      chk($sformatf("v%0d_stall", i), int'(STALL), int'(e.st));
      chk($sformatf("v%0d_state", i), int'(STATE), int'(e.sta));
      chk($sformatf("v%0d_load_count", i), int'(LOAD_COUNT), int'(e.lc));
      chk($sformatf("v%0d_stall_cycles", i), int'(STALL_CYCLES), e.sc);
    end

    // reset while draining with two loads outstanding
    @(negedge CLK); drive_instr(1'b1, 5'd0, 1'b0, 5'd13, 1'b0);
    @(negedge CLK); drive_instr(1'b1, 5'd0, 1'b0, 5'd14, 1'b0);
    @(negedge CLK); drive_instr(1'b0, 5'd13, 1'b1, 5'd15, 1'b1);
    @(negedge CLK); drive_instr(1'b0, 5'd13, 1'b1, 5'd15, 1'b0);
    #1;
    chk("drain_state", int'(STATE), 2);
    chk("drain_load_count", int'(LOAD_COUNT), 2);
    RST = 1'b1;
    #1;
    chk("arst_issue_valid", int'(ISSUE_VALID), 0);
    chk("arst_ins_ready", int'(INS_READY), 0);
    chk("arst_stall", int'(STALL), 0);
    chk("arst_bubble", int'(BUBBLE), 1);
    chk("arst_state", int'(STATE), 0);
    chk("arst_load_count", int'(LOAD_COUNT), 0);
    @(negedge CLK);
    RST = 1'b0;
    #2;
    chk("post_rst_state", int'(STATE), 0);
    chk("post_rst_issue_x13", int'(ISSUE_VALID), 1);
    chk("post_rst_stall_cycles", int'(STALL_CYCLES), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
